// File: rtl/fifo_rr_drain_arb_if.sv
// fifo_rr_drain_arb_if: FIFO-bank pop/read side plus the downstream ready/valid channel.
interface fifo_rr_drain_arb_if #(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 16
);
    localparam int QW = $clog2(NUM_Q);
    logic                   enable;
    logic [NUM_Q-1:0]       q_empty;
    logic [NUM_Q-1:0]       q_pop;
    logic [NUM_Q*WIDTH-1:0] q_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [QW-1:0]          out_qid;
    logic                   busy;
    modport slave (
        input  enable, q_empty, q_rdata, out_ready,
        output q_pop, out_valid, out_data, out_qid, busy
    );
    modport master (
        output enable, q_empty, q_rdata, out_ready,
        input  q_pop, out_valid, out_data, out_qid, busy
    );
endinterface

// File: rtl/fifo_rr_drain_arb.sv
// fifo_rr_drain_arb: round-robin drain of NUM_Q FIFOs into one credit-protected output buffer.
// Define RR_ARB_BURST_EN to let a granted queue keep the grant for up to BURST consecutive pops.
module fifo_rr_drain_arb #(
    parameter int NUM_Q = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 1,
    parameter int OBUF  = 3,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fifo_rr_drain_arb_if.slave bus_io
);
    localparam int QW = $clog2(NUM_Q);
    localparam int PW = (OBUF > 1) ? $clog2(OBUF) : 1;
    localparam int CW = $clog2(OBUF + 1);

    if (NUM_Q < 2 || LAT < 1 || OBUF < LAT + 1 || BURST < 1) begin : g_bad_cfg
        $error("fifo_rr_drain_arb: illegal parameter set");
    end

    logic [QW-1:0]    rr_q, gnt_id, idx;
    logic             gnt_v, can_issue, push, pop;
    logic [LAT-1:0]   tv_q;
    logic [QW-1:0]    tid_q [LAT];
    logic [WIDTH-1:0] rd_a [NUM_Q];
    logic [WIDTH-1:0] bd_q [OBUF];
    logic [QW-1:0]    bq_q [OBUF];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    int               infl;

`ifdef RR_ARB_BURST_EN
    localparam int BW = $clog2(BURST + 1);
    logic          bact_q;
    logic [QW-1:0] owner_q;
    logic [BW-1:0] bcnt_q, nb;
    assign nb = (bact_q && gnt_id == owner_q) ? bcnt_q + 1'b1 : BW'(1);
`endif

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(OBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        infl = 0;
        for (int i = 0; i < LAT; i++) infl += int'(tv_q[i]);
        for (int i = 0; i < NUM_Q; i++) rd_a[i] = bus_io.q_rdata[i*WIDTH +: WIDTH];
    end

    // Credits count reads in flight plus buffered words; a same-cycle dequeue is not credited.
    assign can_issue = rst_n && bus_io.enable && (int'(cnt_q) + infl < OBUF);

    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            idx = QW'((int'(rr_q) + k) % NUM_Q);
            if (!bus_io.q_empty[idx]) begin
                gnt_v  = can_issue;
                gnt_id = idx;
            end
        end
`ifdef RR_ARB_BURST_EN
        if (bact_q && !bus_io.q_empty[owner_q]) begin
            gnt_v  = can_issue;
            gnt_id = owner_q;
        end
`endif
    end

    assign bus_io.q_pop     = gnt_v ? (NUM_Q'(1) << gnt_id) : '0;
    assign push             = tv_q[LAT-1];
    assign pop              = bus_io.out_valid && bus_io.out_ready;
    assign cnt_d            = cnt_q + CW'(push) - CW'(pop);
    assign bus_io.out_valid = (cnt_q != '0);
    assign bus_io.out_data  = bd_q[rd_q];
    assign bus_io.out_qid   = bq_q[rd_q];
    assign bus_io.busy      = (infl != 0) || (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= '0;
            tv_q  <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < LAT; i++) tid_q[i] <= '0;
            for (int i = 0; i < OBUF; i++) begin
                bd_q[i] <= '0;
                bq_q[i] <= '0;
            end
`ifdef RR_ARB_BURST_EN
            bact_q  <= 1'b0;
            owner_q <= '0;
            bcnt_q  <= '0;
`endif
        end else begin
            if (gnt_v) rr_q <= (gnt_id == QW'(NUM_Q - 1)) ? '0 : gnt_id + 1'b1;
            tv_q[0]  <= gnt_v;
            tid_q[0] <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tv_q[i]  <= tv_q[i-1];
                tid_q[i] <= tid_q[i-1];
            end
            if (push) begin
                bd_q[wr_q] <= rd_a[tid_q[LAT-1]];
                bq_q[wr_q] <= tid_q[LAT-1];
                wr_q       <= nxt(wr_q);
            end
            if (pop) rd_q <= nxt(rd_q);
            cnt_q <= cnt_d;
`ifdef RR_ARB_BURST_EN
            // A burst closes on its BURST-th grant or on any idle cycle; rr_q already points past the owner.
            if (!gnt_v || nb == BW'(BURST)) begin
                bact_q  <= 1'b0;
                owner_q <= '0;
                bcnt_q  <= '0;
            end else begin
                bact_q  <= 1'b1;
                owner_q <= gnt_id;
                bcnt_q  <= nb;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fifo_rr_drain_arb.sv
// tb_fifo_rr_drain_arb: randomized scoreboard bench; FIFO bank and arbitration rules modelled with queues.
// The reference model follows RR_ARB_BURST_EN the same way the design does.
module tb_fifo_rr_drain_arb;
    localparam int N = 4, W = 16, LAT = 1, OBUF = 3, BURST = 4;

    typedef struct { logic [N-1:0] pop; logic v; logic b; logic r; } cyc_t;
    typedef struct { logic [1:0] id; logic [W-1:0] d; } word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fifo_rr_drain_arb_if #(.NUM_Q(N), .WIDTH(W)) bus ();
    fifo_rr_drain_arb #(.NUM_Q(N), .WIDTH(W), .LAT(LAT), .OBUF(OBUF), .BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n), .bus_io(bus)
    );
    always #5 clk = ~clk;

    logic [W-1:0] fq [N][$];
    cyc_t  exp_q [$];
    word_t sb [$];
    int    mrdy [$];
    int    ld [N];
    int    cyc = 0, rr = 0, owner = 0, bc = 0;
    bit    bact = 1'b0, done = 1'b0;
    int    total = 0, bad = 0;
    logic [N-1:0] pop_s;

    // Grants follow the rules directly; each granted word becomes visible LAT+1 cycles later and
    // occupies a credit until it is taken downstream.
    task automatic model();
        int g = -1;
        cyc_t e;
        word_t w;
        if (!rst_n) begin
            mrdy.delete();
            sb.delete();
            rr = 0; bact = 1'b0; bc = 0; owner = 0;
            e.pop = '0; e.v = 1'b0; e.b = 1'b0; e.r = 1'b1;
            exp_q.push_back(e);
            cyc++;
            return;
        end
        if (bus.enable && mrdy.size() < OBUF) begin
            for (int k = 0; k < N; k++)
                if (g < 0 && fq[(rr + k) % N].size() > 0) g = (rr + k) % N;
`ifdef RR_ARB_BURST_EN
            if (bact && fq[owner].size() > 0) g = owner;
`endif
        end
        e.pop = (g >= 0) ? (N'(1) << g) : '0;
        e.v   = mrdy.size() > 0 && mrdy[0] <= cyc;
        e.b   = mrdy.size() > 0;
        e.r   = 1'b0;
        exp_q.push_back(e);
        if (e.v && bus.out_ready) void'(mrdy.pop_front());
        if (g >= 0) begin
            w.id = 2'(g);
            w.d  = fq[g][0];
            sb.push_back(w);
            mrdy.push_back(cyc + LAT + 1);
            rr = (g + 1) % N;
`ifdef RR_ARB_BURST_EN
            bc    = (bact && g == owner) ? bc + 1 : 1;
            bact  = bc < BURST;
            owner = bact ? g : 0;
            if (!bact) bc = 0;
`endif
        end
`ifdef RR_ARB_BURST_EN
        else begin
            bact = 1'b0; bc = 0; owner = 0;
        end
`endif
        cyc++;
    endtask

    task automatic step(input bit en, input int pr, input int pp, input bit rs);
        @(negedge clk);
        pop_s = bus.q_pop;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (pop_s[i] && fq[i].size() > 0) bus.q_rdata[i*W +: W] = fq[i].pop_front();
        for (int i = 0; i < N; i++) begin
            repeat (ld[i]) fq[i].push_back(W'($urandom));
            ld[i] = 0;
            if ($urandom_range(99) < pp) fq[i].push_back(W'($urandom));
            bus.q_empty[i] = (fq[i].size() == 0);
        end
        rst_n         = rs;
        bus.enable    = en;
        bus.out_ready = $urandom_range(99) < pr;
        model();
    endtask

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, want, $time);
        end
    endtask

    initial begin
        cyc_t e;
        word_t w;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            chk("q_pop", int'(bus.q_pop), int'(e.pop));
            chk("out_valid", int'(bus.out_valid), int'(e.v));
            chk("busy", int'(bus.busy), int'(e.b));
            if (e.r) begin
                chk("rst_out_data", int'(bus.out_data), 0);
                chk("rst_out_qid", int'(bus.out_qid), 0);
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out: got qid %0d data %0d want no output", bus.out_qid, bus.out_data);
                end else begin
                    total--;
                    w = sb.pop_front();
                    chk("out_qid", int'(bus.out_qid), int'(w.id));
                    chk("out_data", int'(bus.out_data), int'(w.d));
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d undelivered words want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.enable = 1'b0; bus.out_ready = 1'b0; bus.q_empty = '1; bus.q_rdata = '0;
        ld = '{0, 0, 0, 0};
        repeat (2) step(0, 0, 0, 0);
        ld = '{6, 2, 0, 0};
        repeat (16) step(1, 100, 0, 1);
        ld = '{2, 2, 2, 2};
        repeat (14) step(1, 100, 0, 1);
        ld = '{0, 0, 3, 0};
        repeat (8) step(1, 100, 0, 1);
        ld = '{3, 3, 3, 3};
        repeat (8) step(1, 0, 0, 1);
        repeat (20) step(1, 100, 0, 1);
        ld = '{0, 2, 0, 0};
        step(1, 100, 0, 1);
        repeat (6) step(0, 100, 0, 1);
        repeat (6) step(1, 100, 0, 1);
        ld = '{3, 3, 3, 3};
        repeat (3) step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        repeat (30) step(1, 100, 0, 1);
        repeat (400) step($urandom_range(9) != 0, int'($urandom_range(100)), 15, 1);
        repeat (60) step(1, 100, 0, 1);
        done = 1'b1;
    end
endmodule
